// File: rtl/table_printer_gen.sv
// Serialises a ROWS x COLS matrix of small counts as ASCII text over a byte-wide UART TX handshake.
// Inputs are snapshotted at start; the stream is a header number, row-major cells and a CR LF trailer.
module table_printer_gen #(
  parameter int unsigned ROWS     = 5,
  parameter int unsigned COLS     = 5,
  parameter int unsigned VAL_W    = 2,
  parameter int unsigned COOL_CYC = 100000,
  parameter int unsigned BUSY_TO  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       skip_zero,
  input  logic                       row_nl,
  input  logic [ROWS*COLS*VAL_W-1:0] info_table,
  input  logic [7:0]                 cnt,
  input  logic                       uart_tx_busy,
  output logic                       uart_tx_en,
  output logic [7:0]                 uart_tx_data,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 current_state
);

  localparam int unsigned TBL_W   = ROWS * COLS * VAL_W;
  localparam int unsigned TMR_MAX = (COOL_CYC > BUSY_TO) ? COOL_CYC : BUSY_TO;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(TBL_W + 1);
  localparam int unsigned RC_W    = 4;
  localparam int unsigned SEQ_W   = 3;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LATCH      = 4'd1,
    HDR_DIGITS = 4'd2,
    CELL_FETCH = 4'd3,
    CELL_CHECK = 4'd4,
    EMIT_SET   = 4'd5,
    TRIG       = 4'd6,
    WAIT_BUSY  = 4'd7,
    WAIT_DONE  = 4'd8,
    COOL       = 4'd9,
    ADVANCE    = 4'd10,
    DONE       = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    PH_HDR  = 2'd0,
    PH_CELL = 2'd1,
    PH_NL   = 2'd2,
    PH_TRL  = 2'd3
  } phase_t;

  localparam state_t AFTER_TX = (COOL_CYC == 0) ? ADVANCE : COOL;

  state_t             state, state_nxt;
  phase_t             phase, phase_nxt;
  logic [RC_W-1:0]    row, row_nxt, col, col_nxt;
  logic [SEQ_W-1:0]   seq, seq_nxt, seq_last;
  logic [TMR_W-1:0]   timer, timer_nxt;

  logic [TBL_W-1:0]   snap_table;
  logic [7:0]         snap_cnt;
  logic               snap_skip, snap_nl;
  logic [3:0]         hdr_h, hdr_t, hdr_o;
  logic [1:0]         hdr_nd;
  logic [VAL_W-1:0]   cell_val;
  logic [3:0]         cell_tens, cell_ones;
  logic               snap_ld, hdr_ld, cell_ld, digit_ld;

  logic [7:0]         tx_byte;
  logic [BIT_W-1:0]   bit_base;
  logic [SEQ_W-1:0]   hdr_pos, val_pos;
  logic               cell_2dig;

  state_t             rfin_state, cfin_state;
  phase_t             rfin_phase, cfin_phase;
  logic [RC_W-1:0]    rfin_row, cfin_row, cfin_col;

  assign current_state = state;

  // Character selected by the current segment and its sub-index
  always_comb begin
    cell_2dig = (cell_tens != 4'd0);
    hdr_pos   = SEQ_W'(seq + SEQ_W'(3) - SEQ_W'(hdr_nd));
    val_pos   = SEQ_W'(seq - SEQ_W'(3) - SEQ_W'(cell_2dig));
    tx_byte   = 8'h20;
    seq_last  = SEQ_W'(1);
    unique case (phase)
      PH_HDR: begin
        seq_last = SEQ_W'(hdr_nd);
        case (hdr_pos)
          3'd0:    tx_byte = 8'h30 + 8'(hdr_h);
          3'd1:    tx_byte = 8'h30 + 8'(hdr_t);
          3'd2:    tx_byte = 8'h30 + 8'(hdr_o);
          default: tx_byte = 8'h20;
        endcase
      end
      PH_CELL: begin
        seq_last = SEQ_W'(5) + SEQ_W'(cell_2dig);
        case (seq)
          3'd0:    tx_byte = 8'h31 + 8'(row);
          3'd1:    tx_byte = 8'h2A;
          3'd2:    tx_byte = 8'h31 + 8'(col);
          3'd3:    tx_byte = 8'h2A;
          default: begin
            case (val_pos)
              3'd0:    tx_byte = 8'h30 + 8'(cell_tens);
              3'd1:    tx_byte = 8'h30 + 8'(cell_ones);
              default: tx_byte = 8'h20;
            endcase
          end
        endcase
      end
      PH_NL, PH_TRL: tx_byte = (seq == SEQ_W'(0)) ? 8'h0D : 8'h0A;
    endcase
  end

  // Where to go after a row finishes and after a cell finishes (or is skipped)
  always_comb begin
    if (row == RC_W'(ROWS - 1)) begin
      rfin_state = EMIT_SET;
      rfin_phase = PH_TRL;
      rfin_row   = row;
    end else begin
      rfin_state = CELL_FETCH;
      rfin_phase = phase;
      rfin_row   = RC_W'(row + 1'b1);
    end
    if (col != RC_W'(COLS - 1)) begin
      cfin_state = CELL_FETCH;
      cfin_phase = phase;
      cfin_row   = row;
      cfin_col   = RC_W'(col + 1'b1);
    end else if (snap_nl) begin
      cfin_state = EMIT_SET;
      cfin_phase = PH_NL;
      cfin_row   = row;
      cfin_col   = col;
    end else begin
      cfin_state = rfin_state;
      cfin_phase = rfin_phase;
      cfin_row   = rfin_row;
      cfin_col   = '0;
    end
  end

  assign bit_base = BIT_W'((32'(row) * COLS + 32'(col)) * VAL_W);

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    row_nxt   = row;
    col_nxt   = col;
    seq_nxt   = seq;
    timer_nxt = '0;
    snap_ld   = 1'b0;
    hdr_ld    = 1'b0;
    cell_ld   = 1'b0;
    digit_ld  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = LATCH;
          snap_ld   = 1'b1;
        end
      end
      LATCH:      state_nxt = HDR_DIGITS;
      HDR_DIGITS: begin
        hdr_ld    = 1'b1;
        phase_nxt = PH_HDR;
        seq_nxt   = '0;
        row_nxt   = '0;
        col_nxt   = '0;
        state_nxt = EMIT_SET;
      end
      CELL_FETCH: begin
        cell_ld   = 1'b1;
        state_nxt = CELL_CHECK;
      end
      CELL_CHECK: begin
        seq_nxt = '0;
        if (snap_skip && (cell_val == '0)) begin
          state_nxt = cfin_state;
          phase_nxt = cfin_phase;
          row_nxt   = cfin_row;
          col_nxt   = cfin_col;
        end else begin
          digit_ld  = 1'b1;
          phase_nxt = PH_CELL;
          state_nxt = EMIT_SET;
        end
      end
      EMIT_SET: if (!uart_tx_busy) state_nxt = TRIG;
      TRIG:     state_nxt = WAIT_BUSY;
      // A UART that never acknowledges must not stall the stream
      WAIT_BUSY: begin
        if (uart_tx_busy)                         state_nxt = WAIT_DONE;
        else if (timer == TMR_W'(BUSY_TO - 1))    state_nxt = AFTER_TX;
        else                                      timer_nxt = TMR_W'(timer + 1'b1);
      end
      WAIT_DONE: if (!uart_tx_busy) state_nxt = AFTER_TX;
      COOL: begin
        if (timer == TMR_W'(COOL_CYC - 1)) state_nxt = ADVANCE;
        else                               timer_nxt = TMR_W'(timer + 1'b1);
      end
      ADVANCE: begin
        if (seq != seq_last) begin
          seq_nxt   = SEQ_W'(seq + 1'b1);
          state_nxt = EMIT_SET;
        end else begin
          seq_nxt = '0;
          unique case (phase)
            PH_HDR: begin
              row_nxt   = '0;
              col_nxt   = '0;
              state_nxt = CELL_FETCH;
            end
            PH_CELL: begin
              state_nxt = cfin_state;
              phase_nxt = cfin_phase;
              row_nxt   = cfin_row;
              col_nxt   = cfin_col;
            end
            PH_NL: begin
              state_nxt = rfin_state;
              phase_nxt = rfin_phase;
              row_nxt   = rfin_row;
              col_nxt   = '0;
            end
            PH_TRL: state_nxt = DONE;
          endcase
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= PH_HDR;
      row   <= '0;
      col   <= '0;
      seq   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      seq   <= seq_nxt;
      timer <= timer_nxt;
    end
  end

  // Snapshot and decimal digit registers; digits settle one state before EMIT_SET
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_table <= '0;
      snap_cnt   <= '0;
      snap_skip  <= 1'b0;
      snap_nl    <= 1'b0;
      hdr_h      <= '0;
      hdr_t      <= '0;
      hdr_o      <= '0;
      hdr_nd     <= 2'd1;
      cell_val   <= '0;
      cell_tens  <= '0;
      cell_ones  <= '0;
    end else begin
      if (snap_ld) begin
        snap_table <= info_table;
        snap_cnt   <= cnt;
        snap_skip  <= skip_zero;
        snap_nl    <= row_nl;
      end
      if (hdr_ld) begin
        hdr_h  <= 4'(snap_cnt / 8'd100);
        hdr_t  <= 4'((snap_cnt / 8'd10) % 8'd10);
        hdr_o  <= 4'(snap_cnt % 8'd10);
        hdr_nd <= (snap_cnt >= 8'd100) ? 2'd3 : ((snap_cnt >= 8'd10) ? 2'd2 : 2'd1);
      end
      if (cell_ld)  cell_val <= VAL_W'(snap_table >> bit_base);
      if (digit_ld) begin
        cell_tens <= 4'(8'(cell_val) / 8'd10);
        cell_ones <= 4'(8'(cell_val) % 8'd10);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      uart_tx_en <= (state_nxt == TRIG);
      if (state_nxt == TRIG) uart_tx_data <= tx_byte;
      busy <= (state_nxt != IDLE) && (state_nxt != DONE);
      done <= (state_nxt == DONE);
    end
  end

endmodule

// File: doc/table_printer_gen.md
Name: table_printer_gen

Overview:
- Parametrised successor to the fixed 5x5 UART table printer.
- Serialises a ROWS x COLS matrix of VAL_W-bit counts as ASCII over the existing byte-wide UART TX handshake.
- Additions: configurable geometry, multi-digit header/values, runtime skip-zero and row-newline modes, input snapshot at start, abort.
- Sits between game-state logic (table, counter) and uart_tx.

Parameters:
ROWS, 5, matrix rows, 1..9
COLS, 5, matrix columns, 1..9
VAL_W, 2, bits per cell, 1..6 (values 0..63)
COOL_CYC, 100000, idle cycles after each byte (0 = none)
BUSY_TO, 1024, max cycles to wait for uart_tx_busy to rise after a trigger

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; accepted only in IDLE
abort  in  1  level; returns to IDLE from any state
skip_zero  in  1  1 = omit cells whose value is 0 (sampled at start)
row_nl  in  1  1 = emit CR LF after each row (sampled at start)
info_table  in  ROWS*COLS*VAL_W  cell (r,c), 0-based, at bits [(r*COLS+c)*VAL_W +: VAL_W]
cnt  in  8  header number
uart_tx_busy  in  1  UART busy
uart_tx_en  out  1  one-cycle send strobe
uart_tx_data  out  8  byte, valid while uart_tx_en is high
busy  out  1  high from start accept through the final byte
done  out  1  one-cycle pulse on normal completion
current_state  out  4  FSM state encoding, debug

Behaviour:
- Reset (async, rst_n low): all outputs 0; FSM in IDLE; counters cleared.
- Start accept, IDLE with start=1:
  - Next edge latches info_table, cnt, skip_zero and row_nl into snapshot registers.
  - busy is set. Later input changes have no effect on output.
- Byte send sequence:
  - TRIG: drive uart_tx_data, pulse uart_tx_en for exactly one cycle. Enter TRIG only when uart_tx_busy=0.
  - WAIT_BUSY: wait for busy=1. If BUSY_TO cycles pass first, treat the byte as sent.
  - WAIT_DONE: wait for busy=0.
  - COOL: COOL_CYC cycles, then the next byte.
- Stream order:
  1. Header: cnt in decimal, no leading zeros (0 -> "0", 7 -> "7", 42 -> "42", 255 -> "255"), then a space.
  2. Cells, row-major, r=0..ROWS-1, c=0..COLS-1. Each emitted cell is: ASCII(r+1), '*', ASCII(c+1), '*', value in decimal with no leading zeros (1-2 digits), ' '.
  3. If skip_zero=1, a zero cell emits nothing and costs at most 2 cycles. If skip_zero=0, a zero cell prints "0".
  4. If row_nl=1, 0x0D 0x0A follows the last column of every row, even when the whole row was skipped.
  5. Trailer: always 0x0D 0x0A after the last cell.
- FSM states: IDLE, LATCH, HDR_DIGITS, CELL_FETCH, CELL_CHECK, EMIT_SET, TRIG, WAIT_BUSY, WAIT_DONE, COOL, ADVANCE, DONE. Encoding fits 4 bits.
  - A byte-sequencer sub-index selects the next character within the header, cell, newline or trailer.
- Completion: DONE pulses done for 1 cycle, clears busy, returns to IDLE. start held high re-triggers on the following cycle.
- Abort (any non-IDLE state):
  - Next edge: IDLE, busy=0, uart_tx_en=0.
  - No done pulse. A byte already handed to the UART is not recalled.
- Arithmetic: decimal conversion by iterative subtraction or constant divide. Must settle before EMIT_SET and must not add bytes. Row and column indices wrap only at ROWS and COLS.
- Edge case: all cells zero with skip_zero=1 emits the header and trailer only.

Test Plan:
1. ROWS=COLS=5, VAL_W=2, COOL_CYC=0, UART model busy 10 cycles per byte. cnt=42, cell(0,0)=3, cell(4,4)=1, others 0, skip_zero=1, row_nl=0 -> stream "42 1*1*3 5*5*1 \r\n"; single done pulse; busy low afterwards.
2. Same table, skip_zero=0, row_nl=1 -> 25 cells printed (zeros as "0"), "\r\n" after cells 5, 10, 15, 20, 25 plus the trailer; total 25*6+12+3 bytes.
3. VAL_W=6, cell(1,2)=63, cnt=0 -> contains "0 " and "2*3*63 "; cnt=255 header -> "255 ".
4. Change info_table and cnt one cycle after start -> output matches the values latched at start.
5. Assert abort during the 5th byte's WAIT_DONE -> IDLE next edge, busy=0, no done pulse. A new start prints the full stream from the header.
6. UART model that never raises busy, BUSY_TO=16 -> each byte advances after 16 cycles and completion still pulses done. Under reset mid-stream, all outputs read 0 immediately.
